// File: rtl/seg7_pkg.sv
// Shared constants and types for the serial 7-segment link receiver.
package seg7_pkg;

  localparam int unsigned FRAME_BITS_DEF = 64;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  typedef enum logic {
    IDLE,
    SHIFT
  } seg7_rx_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-hex decoder; valid only for an exact table match.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] glyph,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (glyph == SEG7_GLYPH[i] && glyph != SEG7_BLANK) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_serial_rx.sv
// Receiver for the 4-wire serial 7-segment link: sync, shift, latch, decode.
// Glyph decode is built only when SEG7_RX_DECODE_EN is defined.
module seg7_serial_rx
  import seg7_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_clk_i,
  input  logic        seg_do_i,
  input  logic        seg_pen_i,
  input  logic        seg_clr_i,
  output logic [63:0] seg_raw_o,
  output logic [7:0]  points_o,
  output logic [31:0] digits_o,
  output logic [7:0]  digit_valid_o,
  output logic        frame_valid_o,
  output logic        frame_err_o
);

  logic [SYNC_STAGES-1:0] clk_sync, do_sync, pen_sync, clr_sync;
  logic                   clk_s, do_s, pen_s, clr_s;
  logic                   clk_d, pen_d;
  logic                   clk_rise, pen_rise, shift_en;
  logic [63:0]            sr, sr_n;
  logic [6:0]             cnt, cnt_n;
  logic [7:0]             pts_n;
  logic [31:0]            dec_digits;
  logic [7:0]             dec_valid;
  seg7_rx_state_t         state;

  // Clear synchronizer resets to the inactive (high) level so reset does not wipe sr.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '0;
      do_sync  <= '0;
      pen_sync <= '0;
      clr_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], seg_clk_i};
      do_sync  <= {do_sync[SYNC_STAGES-2:0], seg_do_i};
      pen_sync <= {pen_sync[SYNC_STAGES-2:0], seg_pen_i};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], seg_clr_i};
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign do_s     = do_sync[SYNC_STAGES-1];
  assign pen_s    = pen_sync[SYNC_STAGES-1];
  assign clr_s    = clr_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;
  assign pen_rise = pen_s & ~pen_d;
  // A latch edge in the same cycle still lets its shift through (pen_d is still low).
  assign shift_en = clk_rise & ~pen_d;

  always_comb begin
    sr_n  = sr;
    cnt_n = cnt;
    if (!clr_s) begin
      sr_n  = '0;
      cnt_n = '0;
    end else if (shift_en) begin
      sr_n  = {sr[62:0], do_s};
      cnt_n = (cnt == 7'h7F) ? cnt : cnt + 7'd1;
    end
    for (int unsigned k = 0; k < 8; k++) begin
      pts_n[k] = ~sr_n[8*k+7];
    end
  end

`ifdef SEG7_RX_DECODE_EN
  for (genvar g = 0; g < 8; g++) begin : g_dec
    seg7_glyph_decode u_dec (
      .glyph  (sr_n[8*g +: 7]),
      .valid  (dec_valid[g]),
      .nibble (dec_digits[4*g +: 4])
    );
  end
`else
  assign dec_digits = '0;
  assign dec_valid  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sr            <= '1;
      cnt           <= '0;
      clk_d         <= 1'b0;
      pen_d         <= 1'b0;
      seg_raw_o     <= '1;
      points_o      <= '0;
      digits_o      <= '0;
      digit_valid_o <= '0;
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      clk_d         <= clk_s;
      pen_d         <= pen_s;
      frame_valid_o <= pen_rise;
      sr            <= sr_n;
      if (pen_rise) begin
        seg_raw_o     <= sr_n;
        points_o      <= pts_n;
        digits_o      <= dec_digits;
        digit_valid_o <= dec_valid;
        if (cnt_n != 7'(FRAME_BITS)) frame_err_o <= 1'b1;
        cnt           <= '0;
        state         <= IDLE;
      end else begin
        cnt <= cnt_n;
        case (state)
          IDLE:    if (shift_en && clr_s) state <= SHIFT;
          SHIFT:   if (!clr_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_serial_rx.sv
// Randomized bench for seg7_serial_rx with a frame-level reference model.
module tb_seg7_serial_rx;

  localparam int unsigned S    = 2;
  localparam int unsigned HOLD = S + 2;
`ifdef SEG7_RX_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seg_clk = 1'b0, seg_do = 1'b0, seg_pen = 1'b0, seg_clr = 1'b1;
  logic [63:0] seg_raw;
  logic [7:0]  points, digit_valid;
  logic [31:0] digits;
  logic        frame_valid, frame_err;

  int checks = 0;
  int failures = 0;

  seg7_serial_rx #(.FRAME_BITS(64), .SYNC_STAGES(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .seg_clk_i     (seg_clk),
    .seg_do_i      (seg_do),
    .seg_pen_i     (seg_pen),
    .seg_clr_i     (seg_clr),
    .seg_raw_o     (seg_raw),
    .points_o      (points),
    .digits_o      (digits),
    .digit_valid_o (digit_valid),
    .frame_valid_o (frame_valid),
    .frame_err_o   (frame_err)
  );

  always #5 clk = ~clk;

  // Hex digit -> active-low {g..a}, straight from the display glyph table.
  logic [6:0] gly [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: link pins observed S+1 clk edges late, bits collected per frame.
  logic [3:0]  hist [S+2];   // {clr,pen,clk,do}, index 0 = newest sample
  logic [63:0] m_bits, m_raw;
  int          m_count;
  logic [7:0]  m_points, m_valid;
  logic [31:0] m_digits;
  logic        m_fv, m_err;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < S + 2; i++) hist[i] = 4'b1000;
      m_bits = '1; m_count = 0; m_raw = '1; m_points = '0; m_digits = '0;
      m_valid = '0; m_fv = 1'b0; m_err = 1'b0;
      started = 1'b1;
    end else begin
      logic [3:0] cur, prev;
      logic [6:0] g;
      for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {seg_clr, seg_pen, seg_clk, seg_do};
      cur  = hist[S];
      prev = hist[S+1];
      if (!cur[3]) begin
        m_bits = '0; m_count = 0;
      end else if (cur[1] && !prev[1] && !prev[2]) begin
        m_bits = {m_bits[62:0], cur[0]};
        if (m_count < 127) m_count++;
      end
      m_fv = cur[2] && !prev[2];
      if (m_fv) begin
        m_raw = m_bits;
        if (m_count != 64) m_err = 1'b1;
        m_count = 0;
        m_digits = '0; m_valid = '0;
        for (int k = 0; k < 8; k++) begin
          m_points[k] = !m_bits[8*k+7];
          g = m_bits[8*k +: 7];
          for (int d = 0; d < 16; d++)
            if (DEC && g == gly[d]) begin
              m_digits[4*k +: 4] = 4'(d);
              m_valid[k] = 1'b1;
            end
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("raw", seg_raw, m_raw);
      cmp("points", 64'(points), 64'(m_points));
      cmp("digits", 64'(digits), 64'(m_digits));
      cmp("digit_valid", 64'(digit_valid), 64'(m_valid));
      cmp("frame_valid", 64'(frame_valid), 64'(m_fv));
      cmp("frame_err", 64'(frame_err), 64'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    seg_do = b; seg_clk = 1'b0;
    tick(HOLD);
    seg_clk = 1'b1;
    tick(HOLD);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    seg_clk = 1'b0;
    tick(HOLD);
  endtask

  task automatic latch();
    seg_pen = 1'b1;
    tick(HOLD);
    seg_pen = 1'b0;
    tick(HOLD + 2);
  endtask

  function automatic logic [63:0] mk_frame(input logic [31:0] dg, input logic [7:0] dp_on);
    logic [63:0] f;
    for (int k = 0; k < 8; k++) f[8*k +: 8] = {~dp_on[k], gly[dg[4*k +: 4]]};
    return f;
  endfunction

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    @(negedge clk);
    cmp(name, act, exp);
  endtask

  initial begin
    logic [63:0] f1, f2, f3, b40;
    tick(3);
    rst = 1'b0;
    tick(10);
    lit("rst_raw", seg_raw, 64'hFFFF_FFFF_FFFF_FFFF);
    lit("rst_err", 64'(frame_err), 64'd0);

    f1 = mk_frame(32'h0123_0456, 8'h00);
    lit("f1_pin", f1, 64'hC0F9_A4B0_C099_9282);
    send_bits(f1, 64);
    latch();
    lit("f1_digits", 64'(digits), DEC ? 64'h0123_0456 : 64'd0);
    lit("f1_valid", 64'(digit_valid), DEC ? 64'hFF : 64'd0);
    lit("f1_err", 64'(frame_err), 64'd0);

    f2 = {8{8'h88}};
    f2[7:0] = 8'hFF;
    f2[31:24] = 8'h08;
    send_bits(f2, 64);
    latch();
    lit("f2_points", 64'(points), 64'h08);
    lit("f2_digits", 64'(digits), DEC ? 64'hAAAA_AAA0 : 64'd0);
    lit("f2_valid", 64'(digit_valid), DEC ? 64'hFE : 64'd0);

    b40 = {24'd0, $urandom(), 8'($urandom())};
    send_bits(b40, 40);
    latch();
    lit("short_err", 64'(frame_err), 64'd1);
    lit("short_raw", seg_raw, {f2[23:0], b40[39:0]});

    send_bits({$urandom(), $urandom()}, 30);
    seg_clr = 1'b0; tick(HOLD);
    seg_clr = 1'b1; tick(HOLD);
    f3 = mk_frame(32'h89AB_CDEF, 8'h5A);
    send_bits(f3, 64);
    latch();
    lit("clr_raw", seg_raw, f3);
    lit("clr_points", 64'(points), 64'h5A);
    lit("clr_digits", 64'(digits), DEC ? 64'h89AB_CDEF : 64'd0);
    lit("clr_err_sticky", 64'(frame_err), 64'd1);

    send_bits({$urandom(), $urandom()}, 20);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(2);
    lit("rst2_raw", seg_raw, 64'hFFFF_FFFF_FFFF_FFFF);
    lit("rst2_err", 64'(frame_err), 64'd0);
    send_bits(mk_frame(32'h7654_3210, 8'h81), 64);
    latch();
    lit("rst2_digits", 64'(digits), DEC ? 64'h7654_3210 : 64'd0);
    lit("rst2_points", 64'(points), 64'h81);
    lit("rst2_err_after", 64'(frame_err), 64'd0);

    for (int t = 0; t < 14; t++) begin
      logic [63:0] f;
      int n;
      for (int k = 0; k < 8; k++)
        f[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom())
                                                  : {1'($urandom()), gly[$urandom_range(0, 15)]};
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : 64;
      if ($urandom_range(0, 4) == 0) begin
        send_bits({$urandom(), $urandom()}, int'($urandom_range(1, 20)));
        seg_clr = 1'b0; tick(HOLD);
        seg_clr = 1'b1; tick(HOLD);
      end
      send_bits(f, n);
      latch();
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
